ahb_arbiter: RTL and testbench
==============================

// Module: ahb_arbiter
// PURPOSE
//  Multi-master AHB bus arbiter: samples HBUSREQ/HLOCK from up to NUM_MASTER bus masters,
//  drives one-hot HGRANT and the address-phase owner HMASTER/HMASTLOCK for the shared bus mux.
//  Sits between the bfm_ahb-style masters and the address/data mux in front of the slaves.
//  Burst- and lock-aware: never re-grants inside a fixed-length burst or a locked sequence.
// PARAMETERS
//  NUM_MASTER   4   number of requesting masters (2..16)
//  DEF_MASTER   0   master granted when no request is pending (must be < NUM_MASTER)
//  MW           4   width of HMASTER (>= clog2(NUM_MASTER))
// PORTS
//  HCLK       in   1           bus clock, all state on rising edge
//  HRESET     in   1           asynchronous reset, active-high
//  HBUSREQ    in   NUM_MASTER  per-master bus request
//  HLOCK      in   NUM_MASTER  per-master lock request
//  HTRANS     in   2           transfer type of current address phase (from bus mux)
//  HBURST     in   3           burst type of current address phase
//  HREADY     in   1           bus ready
//  HRESP      in   2           slave response
//  HGRANT     out  NUM_MASTER  one-hot grant, registered
//  HMASTER    out  MW          index of master owning current address phase
//  HMASTLOCK  out  1           current address phase is locked
// BEHAVIOUR
//  Reset (async, HRESET=1): HGRANT=1<<DEF_MASTER, HMASTER=DEF_MASTER, HMASTLOCK=0, beat_cnt=0,
//   state=IDLE, rr pointer=0. Reset mid-burst aborts immediately to these values.
//  States: IDLE (default master granted, no requests), GRANT (single/INCR ownership),
//   BURST (fixed-length burst in progress), LOCK (locked sequence in progress).
//  Arbitration point (AP): HREADY=1 and state in {IDLE,GRANT}, or BURST with beat_cnt==1 and
//   HTRANS=SEQ (last address beat), or LOCK with granted HLOCK=0.
//  At AP: winner chosen from HBUSREQ; HGRANT updates at next HCLK edge (1-cycle latency).
//   No requests -> DEF_MASTER, state IDLE. Current owner still requesting at AP in GRANT
//   is eligible like any other master (no parking bias).
//  Priority: fixed, lowest index wins (see CONFIGURATION for round-robin).
//  Burst counter: on HTRANS=NONSEQ & HREADY=1, beat_cnt loads 3/7/15 for INCR4|WRAP4 /
//   INCR8|WRAP8 / INCR16|WRAP16 and state->BURST; SINGLE/INCR keep state GRANT.
//   SEQ & HREADY=1 decrements; reaching 0 -> GRANT. BUSY/IDLE inside burst hold count.
//  Lock: granted master with HLOCK=1 at AP keeps grant, state->LOCK until its HLOCK=0 at AP.
//  HMASTER/HMASTLOCK: load grant index / HLOCK[grant] on every HREADY=1 edge (address phase
//   follows grant by one ready cycle); hold while HREADY=0.
//  HRESP ERROR/RETRY/SPLIT with HREADY=1: beat_cnt cleared, state->GRANT (early AP next cycle).
//  HREADY=0: HGRANT, HMASTER, state, beat_cnt all hold regardless of request changes.
//  Requests at non-AP cycles are ignored until the next AP; HBUSREQ drop never truncates a
//   fixed burst. HGRANT always exactly one-hot.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: search starts at (last_winner+1) mod NUM_MASTER, rr pointer
//   updated at each AP that grants a requesting master; IDLE grants do not move it.
//  Undefined: fixed priority, index 0 highest; no rr pointer register.
// STRUCTURE
//  Package ahb_arb_pkg: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HBURST codes, HRESP codes,
//   state encoding, beat-count-from-HBURST function.
//  Sub-module ahb_arb_pick: combinational one-hot picker (req vector, start index -> winner);
//   arbiter top holds FSM, beat counter, grant/master registers.
// TESTING
//  Reset, no requests -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0; hold for 10 cycles.
//  HBUSREQ=4'b0110 same cycle, HREADY=1 -> HGRANT=4'b0010 next edge (fixed); master 2 after
//   master 1 releases.
//  M1 INCR4 burst, M3 requests on beat 2 -> HGRANT stays 4'b0010 until 4th address beat,
//   then 4'b1000; insert HREADY=0 for 3 cycles mid-burst -> no grant change.
//  M2 HLOCK=1 with two SINGLE transfers, M0 requesting -> HMASTLOCK=1, grant stays M2 until
//   HLOCK drops, then HGRANT=4'b0001.
//  ARB_ROUND_ROBIN_EN, all four requesting SINGLE continuously -> grants cycle 0,1,2,3,0.
//  Assert HRESET during INCR8 beat 5 -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helper for the AHB arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BURST,
    ST_LOCK
  } arb_state_e;

  localparam int unsigned BEAT_W = 4;

  // Beats remaining after the NONSEQ beat; zero means undefined length or single.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      BURST_WRAP4,  BURST_INCR4:  return BEAT_W'(3);
      BURST_WRAP8,  BURST_INCR8:  return BEAT_W'(7);
      BURST_WRAP16, BURST_INCR16: return BEAT_W'(15);
      default:                    return '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration bus between AHB masters / bus mux and the arbiter.
// master: request side; slave: the arbiter itself.
interface ahb_arbiter_if #(
  parameter int NUM_MASTER = 4,
  parameter int MW         = 4
);
  logic [NUM_MASTER-1:0] HBUSREQ;
  logic [NUM_MASTER-1:0] HLOCK;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic                  HREADY;
  logic [1:0]            HRESP;
  logic [NUM_MASTER-1:0] HGRANT;
  logic [MW-1:0]         HMASTER;
  logic                  HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational one-hot picker: first set request at or after `start`, wrapping.
// With start tied to zero this is plain fixed priority, index 0 highest.
module ahb_arb_pick #(
  parameter int NUM_MASTER = 4,
  parameter int MW         = 4
) (
  input  logic [NUM_MASTER-1:0] req,
  input  logic [MW-1:0]         start,
  output logic [NUM_MASTER-1:0] onehot,
  output logic [MW-1:0]         idx,
  output logic                  valid
);
  localparam int unsigned N = NUM_MASTER;

  int unsigned pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(start) + i;
      if (pos >= N) pos = pos - N;
      // Inner scan keeps every index constant so no variable-width part-select is needed.
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid && req[j] && (j == pos)) begin
          onehot[j] = 1'b1;
          idx       = MW'(j);
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Burst- and lock-aware AHB arbiter: registered one-hot HGRANT, HMASTER/HMASTLOCK tracking.
// Define ARB_ROUND_ROBIN_EN for round-robin search; default build is fixed priority.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTER = 4,
  parameter int DEF_MASTER = 0,
  parameter int MW         = 4
) (
  input logic          HCLK,
  input logic          HRESET,
  ahb_arbiter_if.slave bus
);

  localparam logic [NUM_MASTER-1:0] DEF_GRANT = NUM_MASTER'(1) << DEF_MASTER;
  localparam logic [MW-1:0]         DEF_IDX   = MW'(DEF_MASTER);
  localparam logic [MW-1:0]         LAST_IDX  = MW'(NUM_MASTER - 1);

  arb_state_e            state, state_n;
  logic [NUM_MASTER-1:0] grant, grant_n;
  logic [MW-1:0]         gidx, gidx_n;
  logic [BEAT_W-1:0]     beat_cnt, beat_cnt_n;
  logic [MW-1:0]         hmaster;
  logic                  hmastlock;

  logic [MW-1:0]         pick_start;
  logic [NUM_MASTER-1:0] pick_onehot;
  logic [MW-1:0]         pick_idx;
  logic                  pick_valid;

  logic                  trans_seq, trans_nonseq, resp_abort;
  logic                  cur_lock, win_lock, arb_point;
  logic [BEAT_W-1:0]     burst_len;

`ifdef ARB_ROUND_ROBIN_EN
  logic [MW-1:0] rr_ptr, rr_ptr_n;
  assign pick_start = rr_ptr;
`else
  assign pick_start = '0;
`endif

  ahb_arb_pick #(
    .NUM_MASTER (NUM_MASTER),
    .MW         (MW)
  ) u_pick (
    .req    (bus.HBUSREQ),
    .start  (pick_start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    trans_seq    = (bus.HTRANS == TRANS_SEQ);
    trans_nonseq = (bus.HTRANS == TRANS_NONSEQ);
    resp_abort   = (bus.HRESP != RESP_OKAY);
    burst_len    = burst_beats(bus.HBURST);
    cur_lock     = |(bus.HLOCK & grant);
    win_lock     = |(bus.HLOCK & pick_onehot);

    case (state)
      ST_IDLE, ST_GRANT: arb_point = 1'b1;
      ST_BURST:          arb_point = trans_seq && (beat_cnt == BEAT_W'(1));
      // A locked owner may also run a fixed burst; release only once it is finished.
      ST_LOCK:           arb_point = !cur_lock &&
                                     ((beat_cnt == '0) || (trans_seq && (beat_cnt == BEAT_W'(1))));
      default:           arb_point = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    gidx_n     = gidx;
    beat_cnt_n = beat_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_n   = rr_ptr;
`endif

    if (bus.HREADY) begin
      if (resp_abort)                     beat_cnt_n = '0;
      else if (trans_nonseq)              beat_cnt_n = burst_len;
      else if (trans_seq && beat_cnt != '0) beat_cnt_n = beat_cnt - BEAT_W'(1);

      if (resp_abort) begin
        state_n = ST_GRANT;
      end else if (trans_nonseq && burst_len != '0 && state != ST_LOCK) begin
        state_n = ST_BURST;
      end else if (arb_point) begin
        if (cur_lock && state != ST_LOCK) begin
          state_n = ST_LOCK;
        end else if (!pick_valid) begin
          state_n = ST_IDLE;
          grant_n = DEF_GRANT;
          gidx_n  = DEF_IDX;
        end else begin
          state_n = win_lock ? ST_LOCK : ST_GRANT;
          grant_n = pick_onehot;
          gidx_n  = pick_idx;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_n = (pick_idx == LAST_IDX) ? '0 : pick_idx + MW'(1);
`endif
        end
      end else if (state == ST_BURST && trans_nonseq) begin
        // Undefined-length transfer started mid-burst: burst is over, re-arbitrate next cycle.
        state_n = ST_GRANT;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      grant     <= DEF_GRANT;
      gidx      <= DEF_IDX;
      beat_cnt  <= '0;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      gidx     <= gidx_n;
      beat_cnt <= beat_cnt_n;
      if (bus.HREADY) begin
        hmaster   <= gidx;
        hmastlock <= cur_lock;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_n;
  end
`endif

  assign bus.HGRANT    = grant;
  assign bus.HMASTER   = hmaster;
  assign bus.HMASTLOCK = hmastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (4 masters, default master 0); honours ARB_ROUND_ROBIN_EN.
module tb_ahb_arbiter;
  import ahb_arb_pkg::*;

  logic        clk;
  logic        rst;
  int unsigned checks;
  int unsigned errors;
  logic [3:0]  exp_g;

  ahb_arbiter_if #(.NUM_MASTER(4), .MW(4)) bus ();

  ahb_arbiter #(
    .NUM_MASTER (4),
    .DEF_MASTER (0),
    .MW         (4)
  ) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = TRANS_IDLE;
    bus.HBURST  = BURST_SINGLE;
    bus.HREADY  = 1'b1;
    bus.HRESP   = RESP_OKAY;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();

    // Reset and idle hold
    tick();
    check("rst_grant", 32'(bus.HGRANT), 32'h1);
    check("rst_master", 32'(bus.HMASTER), 32'h0);
    check("rst_lock", 32'(bus.HMASTLOCK), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_grant", 32'(bus.HGRANT), 32'h1);
    end
    check("idle_master", 32'(bus.HMASTER), 32'h0);
    check("idle_lock", 32'(bus.HMASTLOCK), 32'h0);

    // Two simultaneous requests: lowest index first, then master 2 after release
    bus.HBUSREQ = 4'b0110;
    tick();
    check("pick_m1", 32'(bus.HGRANT), 32'h2);
    check("pick_m1_master", 32'(bus.HMASTER), 32'h0);
    bus.HBUSREQ = 4'b0100;
    tick();
    check("pick_m2", 32'(bus.HGRANT), 32'h4);
    check("pick_m2_master_lag", 32'(bus.HMASTER), 32'h1);
    tick();
    check("pick_m2_master", 32'(bus.HMASTER), 32'h2);
    bus.HBUSREQ = 4'b0000;
    tick();
    check("release_def", 32'(bus.HGRANT), 32'h1);

    // M1 INCR4 with M3 requesting from beat 2 and three wait states
    do_reset();
    bus.HBUSREQ = 4'b0010;
    tick();
    check("burst_grant", 32'(bus.HGRANT), 32'h2);
    tick();
    check("burst_owner", 32'(bus.HMASTER), 32'h1);
    bus.HTRANS = TRANS_NONSEQ;
    bus.HBURST = BURST_INCR4;
    tick();
    check("burst_b1", 32'(bus.HGRANT), 32'h2);
    bus.HTRANS  = TRANS_SEQ;
    bus.HBUSREQ = 4'b1000;
    tick();
    check("burst_b2", 32'(bus.HGRANT), 32'h2);
    bus.HREADY  = 1'b0;
    bus.HBUSREQ = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_grant", 32'(bus.HGRANT), 32'h2);
      check("wait_master", 32'(bus.HMASTER), 32'h1);
    end
    bus.HREADY  = 1'b1;
    bus.HBUSREQ = 4'b1000;
    tick();
    check("burst_b3", 32'(bus.HGRANT), 32'h2);
    tick();
    check("burst_b4_regrant", 32'(bus.HGRANT), 32'h8);
    check("burst_b4_master", 32'(bus.HMASTER), 32'h1);
    bus.HTRANS = TRANS_IDLE;
    tick();
    check("burst_next_master", 32'(bus.HMASTER), 32'h3);

    // Locked sequence by M2 with M0 requesting
    do_reset();
    bus.HBUSREQ = 4'b0100;
    bus.HLOCK   = 4'b0100;
    tick();
    check("lock_grant", 32'(bus.HGRANT), 32'h4);
    check("lock_mlock_lag", 32'(bus.HMASTLOCK), 32'h0);
    bus.HBUSREQ = 4'b0101;
    tick();
    check("lock_hold0", 32'(bus.HGRANT), 32'h4);
    check("lock_mlock", 32'(bus.HMASTLOCK), 32'h1);
    check("lock_master", 32'(bus.HMASTER), 32'h2);
    bus.HTRANS = TRANS_NONSEQ;
    bus.HBURST = BURST_SINGLE;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lock_single", 32'(bus.HGRANT), 32'h4);
      check("lock_single_ml", 32'(bus.HMASTLOCK), 32'h1);
    end
    bus.HLOCK  = 4'b0000;
    bus.HTRANS = TRANS_IDLE;
    tick();
    check("unlock_grant", 32'(bus.HGRANT), 32'h1);
    check("unlock_mlock", 32'(bus.HMASTLOCK), 32'h0);

    // All four requesting SINGLE continuously
    do_reset();
    bus.HBUSREQ = 4'b1111;
    bus.HTRANS  = TRANS_NONSEQ;
    bus.HBURST  = BURST_SINGLE;
    for (int k = 0; k < 5; k++) begin
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = 4'b0001 << (k % 4);
`else
      exp_g = 4'b0001;
`endif
      check("all_req", 32'(bus.HGRANT), 32'(exp_g));
    end

    // ERROR response inside an INCR8 burst ends it early
    do_reset();
    bus.HBUSREQ = 4'b0010;
    tick();
    tick();
    bus.HTRANS = TRANS_NONSEQ;
    bus.HBURST = BURST_INCR8;
    tick();
    bus.HTRANS  = TRANS_SEQ;
    bus.HBUSREQ = 4'b1000;
    tick();
    check("err_pre", 32'(bus.HGRANT), 32'h2);
    bus.HRESP  = RESP_ERROR;
    bus.HREADY = 1'b0;
    tick();
    check("err_wait", 32'(bus.HGRANT), 32'h2);
    bus.HREADY = 1'b1;
    tick();
    check("err_hold", 32'(bus.HGRANT), 32'h2);
    bus.HRESP  = RESP_OKAY;
    bus.HTRANS = TRANS_IDLE;
    tick();
    check("err_rearb", 32'(bus.HGRANT), 32'h8);

    // Asynchronous reset during INCR8 beat 5
    do_reset();
    bus.HBUSREQ = 4'b0010;
    tick();
    tick();
    bus.HTRANS = TRANS_NONSEQ;
    bus.HBURST = BURST_INCR8;
    tick();
    bus.HTRANS = TRANS_SEQ;
    for (int i = 0; i < 3; i++) tick();
    check("b5_grant", 32'(bus.HGRANT), 32'h2);
    check("b5_master", 32'(bus.HMASTER), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_grant", 32'(bus.HGRANT), 32'h1);
    check("arst_master", 32'(bus.HMASTER), 32'h0);
    check("arst_lock", 32'(bus.HMASTLOCK), 32'h0);
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    check("post_arst_grant", 32'(bus.HGRANT), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
